// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encodings,
// common ALU op constants and a counter-width helper.
package serial_adder_pkg;

  // FSM state encodings shared with the rest of the ALU side path
  typedef enum logic [1:0] {
    SA_IDLE = 2'd0,
    SA_RUN  = 2'd1,
    SA_DONE = 2'd2
  } sa_state_e;

  // Common ALU op constants (value driven onto the sub input)
  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  // Width of a counter that must hold 0..n-1; never narrower than one bit
  function automatic int cnt_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Combinational ripple of DIGIT full-adder cells. Also exposes the carry
// into the top cell so the caller can derive signed overflow.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c_s;

  // Ripple the carry through DIGIT full-adder cells, LSB first
  always_comb begin
    s        = {DIGIT{1'b0}};
    c_s      = {(DIGIT+1){1'b0}};
    c_s[0]   = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]     = a[i] ^ b[i] ^ c_s[i];
      c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c_s[DIGIT];
  assign c_msb = c_s[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, WIDTH/DIGIT cycles
// per operation, start/busy/done handshake, carry-out and signed overflow.
// Operands are held in shift registers so the active slice is always the
// low DIGIT bits; the partial sum is shifted in from the top, so after the
// last slice it is fully aligned without any variable indexing.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("serial_adder: WIDTH (%0d) must be a positive multiple of DIGIT (%0d)", WIDTH, DIGIT);
  end

  sa_state_e        state_r, state_n;
  logic             accept_s, last_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] opa_r, opb_r, psum_r;
  logic             carry_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r, ovf_r, busy_r, done_r;

  logic [DIGIT-1:0]       slice_s;
  logic                   slice_co_s, slice_cmsb_s;
  logic [WIDTH+DIGIT-1:0] opa_wide_s, opb_wide_s, psum_wide_s;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a     (opa_r[DIGIT-1:0]),
    .b     (opb_r[DIGIT-1:0]),
    .ci    (carry_r),
    .s     (slice_s),
    .co    (slice_co_s),
    .c_msb (slice_cmsb_s)
  );

  assign opa_wide_s  = {{DIGIT{1'b0}}, opa_r};
  assign opb_wide_s  = {{DIGIT{1'b0}}, opb_r};
  assign psum_wide_s = {slice_s, psum_r};

  // State register; reset wins over everything, including a run in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= SA_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic plus accept/last-slice strobes for the datapath
  always_comb begin
    state_n  = state_r;
    accept_s = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      SA_IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          state_n  = SA_RUN;
        end else begin
          state_n  = SA_IDLE;
        end
      end
      SA_RUN: begin
        if (cnt_r == LAST_CNT) begin
          last_s  = 1'b1;
          state_n = SA_DONE;
        end else begin
          state_n = SA_RUN;
        end
      end
      SA_DONE: begin
        if (start) begin
          accept_s = 1'b1;
          state_n  = SA_RUN;
        end else begin
          state_n  = SA_IDLE;
        end
      end
      default: begin
        state_n = SA_IDLE;
      end
    endcase
  end

  // Operand capture, per-slice accumulation and result/flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r   <= {CNT_W{1'b0}};
      opa_r   <= {WIDTH{1'b0}};
      opb_r   <= {WIDTH{1'b0}};
      psum_r  <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (accept_s) begin
      // Subtraction is a + ~b + ~borrow
      opa_r   <= a;
      opb_r   <= sub ? ~b : b;
      carry_r <= sub ? ~cin : cin;
      cnt_r   <= {CNT_W{1'b0}};
      psum_r  <= {WIDTH{1'b0}};
      busy_r  <= 1'b1;
      done_r  <= 1'b0;
    end else if (state_r == SA_RUN) begin
      opa_r   <= opa_wide_s[WIDTH+DIGIT-1:DIGIT];
      opb_r   <= opb_wide_s[WIDTH+DIGIT-1:DIGIT];
      psum_r  <= psum_wide_s[WIDTH+DIGIT-1:DIGIT];
      carry_r <= slice_co_s;
      cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      if (last_s) begin
        sum_r  <= psum_wide_s[WIDTH+DIGIT-1:DIGIT];
        cout_r <= slice_co_s;
        ovf_r  <= slice_cmsb_s ^ slice_co_s;
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign sum      = sum_r;
  assign cout     = cout_r;
  assign overflow = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random bench for serial_adder at WIDTH=8, DIGIT=4 (N=2).
module tb_serial_adder;

  localparam int W = 8;
  localparam int D = 4;
  localparam int N = W / D;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin, sub;
  logic         busy, done, cout, overflow;
  logic [W-1:0] sum;

  int checks;
  int failures;

  serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".sum"}, 32'(sum), 32'd0);
    chk({tag, ".cout"}, 32'(cout), 32'd0);
    chk({tag, ".ovf"}, 32'(overflow), 32'd0);
  endtask

  // Independent reference: signed integer arithmetic and unsigned compare
  function automatic logic [9:0] model(input logic [7:0] ma, mb, input logic mc, ms);
    int sa, sb, ires, ua, ub, uc;
    logic mcout, movf;
    logic [7:0] msum;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    ua = int'(ma);
    ub = int'(mb);
    uc = int'(mc);
    if (ms) begin
      ires  = sa - sb - uc;
      mcout = (ua >= ub + uc);
    end else begin
      ires  = sa + sb + uc;
      mcout = (ua + ub + uc) > 255;
    end
    movf = (ires > 127) || (ires < -128);
    msum = ires[7:0];
    return {movf, mcout, msum};
  endfunction

  // Issue one op at the current negedge and follow it to its done pulse
  task automatic run_op(input string tag, input logic [7:0] ta, tb, input logic tcin, tsub,
                        input logic [7:0] es, input logic ec, eo);
    int cyc;
    a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~ta; b = ~tb; cin = ~tcin; sub = ~tsub;
    cyc = 1;
    while (!done && cyc < 10) begin
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".latency"}, 32'(cyc), 32'(N + 1));
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".busy_end"}, 32'(busy), 32'd0);
    chk({tag, ".sum"}, 32'(sum), 32'(es));
    chk({tag, ".cout"}, 32'(cout), 32'(ec));
    chk({tag, ".ovf"}, 32'(overflow), 32'(eo));
  endtask

  initial begin
    logic [9:0] exp_v;
    logic [7:0] ra, rb;
    logic       rc, rs;
    checks = 0;
    failures = 0;
    reset = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1; sub = 1'b0;

    // Reset with start held high for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle_outputs("reset_hold");
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk_idle_outputs("post_reset");

    // Additions
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("add_ff_01_c", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);

    // Subtractions
    run_op("sub_00_01", 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Let the machine go idle, then start while busy must be ignored
    @(negedge clk);
    chk("idle_gap.done", 32'(done), 32'd0);
    a = 8'h55; b = 8'h22; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h11; b = 8'h11; cin = 1'b1; sub = 1'b1;
    chk("ign.busy1", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    chk("ign.busy2", 32'(busy), 32'd1);
    @(negedge clk);
    chk("ign.done", 32'(done), 32'd1);
    chk("ign.sum", 32'(sum), 32'h77);
    chk("ign.cout", 32'(cout), 32'd0);

    // Back-to-back: start in the done cycle; old result held meanwhile
    a = 8'h10; b = 8'h20; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b.done_drop", 32'(done), 32'd0);
    chk("b2b.busy", 32'(busy), 32'd1);
    chk("b2b.hold_sum", 32'(sum), 32'h77);
    @(negedge clk);
    chk("b2b.hold_sum2", 32'(sum), 32'h77);
    @(negedge clk);
    chk("b2b.done", 32'(done), 32'd1);
    chk("b2b.sum", 32'(sum), 32'h30);
    chk("b2b.ovf", 32'(overflow), 32'd0);

    // Reset on a RUN edge discards the op
    a = 8'h7F; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_run.busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle_outputs("rst_run");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_idle_outputs("rst_run_after");
    end
    run_op("after_rst", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

    // Random back-to-back sweep against the reference model
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      exp_v = model(ra, rb, rc, rs);
      run_op("rand", ra, rb, rc, rs, exp_v[7:0], exp_v[8], exp_v[9]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always ends
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "bench time limit reached");
  end

endmodule
